// File: rtl/mem_port_master_if.sv
// mem_port_master_if: requester-side handshake bundle for mem_port_master.
//   master modport : the requester (drives req/we/addr/wdata)
//   slave modport  : mem_port_master (drives ready/done/rdata/verify_err)
interface mem_port_master_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic              done;
   logic [DATA_W-1:0] rdata;
   logic              verify_err;

   modport master (
      output req, we, addr, wdata,
      input  ready, done, rdata, verify_err
   );

   modport slave (
      input  req, we, addr, wdata,
      output ready, done, rdata, verify_err
   );
endinterface

// File: rtl/mem_port_master.sv
// mem_port_master: single-access sequencer in front of a synchronous RAM
// with one-cycle read latency. One request is accepted while idle, issued
// to the RAM for exactly one cycle, and completed with a one-cycle done
// pulse. Every RAM-facing output and every requester-facing output comes
// straight from a register.
//
// Optional feature: define MEM_PORT_MASTER_WRITE_VERIFY_EN to read back
// each written word and flag a mismatch on verify_err. Without it the
// verify states do not exist and verify_err is tied low.
module mem_port_master #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              resetn,
   mem_port_master_if.slave  bus,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

`ifdef MEM_PORT_MASTER_WRITE_VERIFY_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_VRD   = 3'd3,
      S_VWAIT = 3'd4,
      S_DONE  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd5
   } state_t;
`endif

   state_t            r_state;
   logic              r_we;
   logic              r_ready;
   logic              r_done;
   logic [DATA_W-1:0] r_rdata;
   logic [ADDR_W-1:0] r_ram_address;
   logic [DATA_W-1:0] r_ram_data;
   logic              r_ram_wren;
`ifdef MEM_PORT_MASTER_WRITE_VERIFY_EN
   logic              r_verify_err;
`endif

   // Sequencer: accept in IDLE, drive the RAM for one cycle in ISSUE, wait
   // out the read latency where needed, pulse done, return to IDLE.
   // ram_address/ram_data double as the latched request (they only change
   // on acceptance), so the verify compare uses ram_data as the reference.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_we          <= 1'b0;
         r_ready       <= 1'b1;
         r_done        <= 1'b0;
         r_rdata       <= '0;
         r_ram_address <= '0;
         r_ram_data    <= '0;
         r_ram_wren    <= 1'b0;
`ifdef MEM_PORT_MASTER_WRITE_VERIFY_EN
         r_verify_err  <= 1'b0;
`endif
      end else begin
         r_done     <= 1'b0;
         r_ram_wren <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_we          <= bus.we;
                  r_ram_address <= bus.addr;
                  r_ram_data    <= bus.wdata;
                  r_ram_wren    <= bus.we;
                  r_ready       <= 1'b0;
                  r_state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_we) begin
`ifdef MEM_PORT_MASTER_WRITE_VERIFY_EN
                  r_state <= S_VRD;
`else
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
`endif
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_rdata <= ram_q;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
`ifdef MEM_PORT_MASTER_WRITE_VERIFY_EN
            S_VRD: begin
               r_state <= S_VWAIT;
            end
            S_VWAIT: begin
               r_verify_err <= (ram_q != r_ram_data);
               r_done       <= 1'b1;
               r_state      <= S_DONE;
            end
`endif
            S_DONE: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ready   = r_ready;
   assign bus.done    = r_done;
   assign bus.rdata   = r_rdata;
   assign ram_address = r_ram_address;
   assign ram_data    = r_ram_data;
   assign ram_wren    = r_ram_wren;
`ifdef MEM_PORT_MASTER_WRITE_VERIFY_EN
   assign bus.verify_err = r_verify_err;
`else
   assign bus.verify_err = 1'b0;
`endif

endmodule
